// File: rtl/spi_reg_bridge_if.sv
// rtl/spi_reg_bridge_if.sv - SPI byte-side and register-bus signals of the SPI register bridge.
interface spi_reg_bridge_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  cs_n;
    logic                  wr_req;
    logic                  rd_req;
    logic [DATA_WIDTH-1:0] spi_rx_byte;
    logic [DATA_WIDTH-1:0] spi_tx_byte;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic                  reg_we;
    logic                  reg_re;
    logic [DATA_WIDTH-1:0] reg_rdata;
    logic                  busy;

    modport slave (
        input  cs_n, wr_req, rd_req, spi_rx_byte, reg_rdata,
        output spi_tx_byte, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

    modport master (
        output cs_n, wr_req, rd_req, spi_rx_byte, reg_rdata,
        input  spi_tx_byte, reg_addr, reg_wdata, reg_we, reg_re, busy
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI byte stream to register bus bridge; SPI_REG_BRIDGE_AUTOINC_EN enables burst address increment.
module spi_reg_bridge #(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    spi_reg_bridge_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WR_DATA,
        S_RD_DATA
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr_cnt;
    logic [ADDR_WIDTH-1:0] r_reg_addr;
    logic [DATA_WIDTH-1:0] r_reg_wdata;
    logic [DATA_WIDTH-1:0] r_tx_byte;
    logic                  r_reg_we;
    logic                  r_reg_re;
    logic                  r_rd_cap;
    logic                  r_busy;

    logic                  w_cmd_rd;
    logic [ADDR_WIDTH-1:0] w_cmd_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;

    assign w_cmd_rd   = bus.spi_rx_byte[DATA_WIDTH-1];
    assign w_cmd_addr = bus.spi_rx_byte[ADDR_WIDTH-1:0];

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    assign w_addr_next = r_addr_cnt + ADDR_WIDTH'(1);
`else
    assign w_addr_next = r_addr_cnt;
`endif

    // r_rd_cap marks the cycle in which reg_rdata answers the previous reg_re.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr_cnt  <= '0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_tx_byte   <= IDLE_BYTE;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_rd_cap    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_reg_we <= 1'b0;
            r_reg_re <= 1'b0;
            r_rd_cap <= 1'b0;
            if (bus.cs_n) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_tx_byte <= IDLE_BYTE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state   <= S_CMD;
                        r_busy    <= 1'b1;
                        r_tx_byte <= IDLE_BYTE;
                    end
                    S_CMD: begin
                        r_tx_byte <= IDLE_BYTE;
                        if (bus.wr_req) begin
                            r_addr_cnt <= w_cmd_addr;
                            if (w_cmd_rd) begin
                                r_state    <= S_RD_DATA;
                                r_reg_re   <= 1'b1;
                                r_reg_addr <= w_cmd_addr;
                            end else begin
                                r_state <= S_WR_DATA;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        r_tx_byte <= IDLE_BYTE;
                        if (bus.wr_req) begin
                            r_reg_we    <= 1'b1;
                            r_reg_wdata <= bus.spi_rx_byte;
                            r_reg_addr  <= r_addr_cnt;
                            r_addr_cnt  <= w_addr_next;
                        end
                    end
                    S_RD_DATA: begin
                        r_rd_cap <= r_reg_re;
                        if (r_rd_cap) begin
                            r_tx_byte <= bus.reg_rdata;
                        end
                        if (bus.rd_req) begin
                            r_addr_cnt <= w_addr_next;
                            r_reg_re   <= 1'b1;
                            r_reg_addr <= w_addr_next;
                        end
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_tx_byte <= IDLE_BYTE;
                    end
                endcase
            end
        end
    end

    assign bus.spi_tx_byte = r_tx_byte;
    assign bus.reg_addr    = r_reg_addr;
    assign bus.reg_wdata   = r_reg_wdata;
    assign bus.reg_we      = r_reg_we;
    assign bus.reg_re      = r_reg_re;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - scoreboard bench for spi_reg_bridge; honours SPI_REG_BRIDGE_AUTOINC_EN.
module tb_spi_reg_bridge;
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    localparam logic [6:0] INC = 7'd1;
`else
    localparam logic [6:0] INC = 7'd0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    logic [14:0] exp_wr[$];
    logic [6:0]  exp_rd[$];

    spi_reg_bridge_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus ();

    spi_reg_bridge #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .IDLE_BYTE(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register model: answers one cycle after reg_re with addr + 0x40.
    always @(posedge clk) begin
        if (reset) bus.reg_rdata <= 8'h00;
        else if (bus.reg_re) bus.reg_rdata <= {1'b0, bus.reg_addr} + 8'h40;
    end

    always @(negedge clk) begin
        if (bus.reg_we === 1'b1) begin
            n_checks++;
            if (bus.reg_re === 1'b1) begin
                n_fail++;
                $display("FAIL we_re_overlap got we=1 re=1 required not both");
            end else if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write got addr=%h data=%h required no write", bus.reg_addr, bus.reg_wdata);
            end else begin
                logic [14:0] e;
                e = exp_wr.pop_front();
                if ({bus.reg_addr, bus.reg_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                             bus.reg_addr, bus.reg_wdata, e[14:8], e[7:0]);
                end
            end
        end
        if (bus.reg_re === 1'b1 && bus.reg_we !== 1'b1) begin
            n_checks++;
            if (exp_rd.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read got addr=%h required no read", bus.reg_addr);
            end else begin
                logic [6:0] ea;
                ea = exp_rd.pop_front();
                if (bus.reg_addr !== ea) begin
                    n_fail++;
                    $display("FAIL read_addr got %h required %h", bus.reg_addr, ea);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic wr, input logic rd, input logic [7:0] b);
        bus.spi_rx_byte = b;
        bus.wr_req      = wr;
        bus.rd_req      = rd;
        @(negedge clk);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained got wr_left=%0d rd_left=%0d required 0 0", name, exp_wr.size(), exp_rd.size());
        end
        exp_wr.delete();
        exp_rd.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(3);
        n_checks++;
        if ({bus.spi_tx_byte, bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_re, bus.busy} !==
            {8'hA5, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs got tx=%h addr=%h wdata=%h we=%b re=%b busy=%b required a5 00 00 0 0 0",
                     bus.spi_tx_byte, bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_re, bus.busy);
        end
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_write_burst;
        bus.cs_n = 1'b0;
        cyc(1);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_busy got %b required 1", bus.busy);
        end
        strobe(1'b1, 1'b0, 8'h05);
        cyc(1);
        exp_wr.push_back({7'h05, 8'h11});
        strobe(1'b1, 1'b0, 8'h11);
        n_checks++;
        if (bus.reg_we !== 1'b1) begin
            n_fail++;
            $display("FAIL write_latency got we=%b required 1", bus.reg_we);
        end
        cyc(2);
        exp_wr.push_back({7'h05 + INC, 8'h22});
        strobe(1'b1, 1'b0, 8'h22);
        cyc(1);
        n_checks++;
        if (bus.spi_tx_byte !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_tx got %h required a5", bus.spi_tx_byte);
        end
        bus.cs_n = 1'b1;
        cyc(2);
        check_drained("write_burst");
    endtask

    task automatic test_read_burst;
        logic [6:0] a;
        bus.cs_n = 1'b0;
        cyc(1);
        a = 7'h03;
        exp_rd.push_back(a);
        strobe(1'b1, 1'b0, 8'h83);
        cyc(2);
        n_checks++;
        if (bus.spi_tx_byte !== {1'b0, a} + 8'h40) begin
            n_fail++;
            $display("FAIL read_first_tx got %h required %h", bus.spi_tx_byte, {1'b0, a} + 8'h40);
        end
        for (int k = 0; k < 2; k++) begin
            a = a + INC;
            exp_rd.push_back(a);
            strobe(1'b0, 1'b1, 8'h00);
            cyc(2);
            n_checks++;
            if (bus.spi_tx_byte !== {1'b0, a} + 8'h40) begin
                n_fail++;
                $display("FAIL read_next_tx got %h required %h", bus.spi_tx_byte, {1'b0, a} + 8'h40);
            end
            strobe(1'b1, 1'b0, 8'hFF);
            cyc(2);
            n_checks++;
            if (bus.spi_tx_byte !== {1'b0, a} + 8'h40) begin
                n_fail++;
                $display("FAIL read_dummy_tx got %h required %h", bus.spi_tx_byte, {1'b0, a} + 8'h40);
            end
        end
        bus.cs_n = 1'b1;
        cyc(1);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.spi_tx_byte !== 8'hA5) begin
            n_fail++;
            $display("FAIL read_end got busy=%b tx=%h required 0 a5", bus.busy, bus.spi_tx_byte);
        end
        cyc(1);
        check_drained("read_burst");
    endtask

    task automatic test_wrap;
        bus.cs_n = 1'b0;
        cyc(1);
        strobe(1'b1, 1'b0, 8'h7F);
        cyc(1);
        exp_wr.push_back({7'h7F, 8'h3C});
        strobe(1'b1, 1'b0, 8'h3C);
        cyc(1);
        exp_wr.push_back({7'h7F + INC, 8'h4D});
        strobe(1'b1, 1'b0, 8'h4D);
        cyc(1);
        bus.cs_n = 1'b1;
        cyc(2);
        check_drained("wrap");
    endtask

    task automatic test_abort;
        bus.cs_n = 1'b0;
        cyc(1);
        exp_rd.push_back(7'h10);
        strobe(1'b1, 1'b0, 8'h90);
        bus.cs_n = 1'b1;
        cyc(1);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.spi_tx_byte !== 8'hA5) begin
            n_fail++;
            $display("FAIL abort_idle got busy=%b tx=%h required 0 a5", bus.busy, bus.spi_tx_byte);
        end
        cyc(4);
        n_checks++;
        if (bus.spi_tx_byte !== 8'hA5 || bus.reg_re !== 1'b0 || bus.reg_we !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_discard got tx=%h re=%b we=%b required a5 0 0",
                     bus.spi_tx_byte, bus.reg_re, bus.reg_we);
        end
        check_drained("abort");
    endtask

    task automatic test_reset_mid_write;
        bus.cs_n = 1'b0;
        cyc(1);
        strobe(1'b1, 1'b0, 8'h05);
        cyc(1);
        reset = 1'b1;
        bus.cs_n = 1'b1;
        strobe(1'b1, 1'b0, 8'h99);
        n_checks++;
        if ({bus.spi_tx_byte, bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_re, bus.busy} !==
            {8'hA5, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_write got tx=%h addr=%h wdata=%h we=%b re=%b busy=%b required a5 00 00 0 0 0",
                     bus.spi_tx_byte, bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_re, bus.busy);
        end
        reset = 1'b0;
        cyc(2);
        check_drained("reset_mid_write");
    endtask

    task automatic test_idle_cmd_output;
        strobe(1'b0, 1'b1, 8'h00);
        n_checks++;
        if (bus.spi_tx_byte !== 8'hA5 || bus.reg_re !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_rd_req got tx=%h re=%b required a5 0", bus.spi_tx_byte, bus.reg_re);
        end
        bus.cs_n = 1'b0;
        cyc(1);
        strobe(1'b0, 1'b1, 8'h00);
        cyc(1);
        n_checks++;
        if (bus.spi_tx_byte !== 8'hA5 || bus.reg_re !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cmd_rd_req got tx=%h re=%b busy=%b required a5 0 1",
                     bus.spi_tx_byte, bus.reg_re, bus.busy);
        end
        strobe(1'b1, 1'b1, 8'h22);
        cyc(1);
        exp_wr.push_back({7'h22, 8'h5A});
        strobe(1'b1, 1'b1, 8'h5A);
        cyc(1);
        n_checks++;
        if (bus.spi_tx_byte !== 8'hA5) begin
            n_fail++;
            $display("FAIL wr_state_tx got %h required a5", bus.spi_tx_byte);
        end
        bus.cs_n = 1'b1;
        cyc(2);
        check_drained("idle_cmd");
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b1;
        bus.cs_n        = 1'b1;
        bus.wr_req      = 1'b0;
        bus.rd_req      = 1'b0;
        bus.spi_rx_byte = 8'h00;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_wrap();
        test_abort();
        test_reset_mid_write();
        test_idle_cmd_output();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
